// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped tag array controller.
// Default entry layout: valid in the MSB, dirty below it, zero pad, tag in the LSBs.
package cache_pkg;

    localparam int CACHE_ADDR_W = 8;
    localparam int CACHE_DATA_W = 32;
    localparam int CACHE_TAG_W  = 22;

    localparam int VALID_BIT = CACHE_DATA_W - 1;
    localparam int DIRTY_BIT = CACHE_DATA_W - 2;

    typedef struct packed {
        logic                                   valid;
        logic                                   dirty;
        logic [CACHE_DATA_W-CACHE_TAG_W-3:0]    pad;
        logic [CACHE_TAG_W-1:0]                 tag;
    } tag_entry_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } tag_state_e;

endpackage

// File: rtl/cache_tag_ctrl_if.sv
// Lookup, update, control and tag-SRAM port-0 signals of cache_tag_ctrl.
// slave is the controller's view; master is the cache FSM / SRAM side.
interface cache_tag_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 22
);
    logic                  lk_valid;
    logic                  lk_ready;
    logic [ADDR_WIDTH-1:0] lk_index;
    logic [TAG_WIDTH-1:0]  lk_tag;

    logic                  rsp_valid;
    logic                  rsp_hit;
    logic                  rsp_dirty;
    logic [TAG_WIDTH-1:0]  rsp_tag;

    logic                  upd_valid;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] upd_index;
    logic [TAG_WIDTH-1:0]  upd_tag;
    logic                  upd_v;
    logic                  upd_d;

    logic                  inv_all;
    logic                  init_done;

    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  sram_web;
    logic [DATA_WIDTH-1:0] sram_wdat;
    logic [DATA_WIDTH-1:0] sram_rdat;

    modport slave (
        input  lk_valid, lk_index, lk_tag,
        output lk_ready,
        output rsp_valid, rsp_hit, rsp_dirty, rsp_tag,
        input  upd_valid, upd_index, upd_tag, upd_v, upd_d,
        output upd_ready,
        input  inv_all,
        output init_done,
        output sram_addr, sram_web, sram_wdat,
        input  sram_rdat
    );

    modport master (
        output lk_valid, lk_index, lk_tag,
        input  lk_ready,
        input  rsp_valid, rsp_hit, rsp_dirty, rsp_tag,
        output upd_valid, upd_index, upd_tag, upd_v, upd_d,
        input  upd_ready,
        output inv_all,
        input  init_done,
        input  sram_addr, sram_web, sram_wdat,
        output sram_rdat
    );

endinterface

// File: rtl/cache_tag_ctrl.sv
// Tag-array port-0 owner: sweep-clear, then one access per cycle (inv_all > update > lookup).
// Lookup result 2 cycles after accept, no response backpressure; updates write in the accept cycle.
module cache_tag_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 22
) (
    input  logic             clk,
    input  logic             rst,
    cache_tag_ctrl_if.slave  bus
);

    localparam int VBIT = DATA_WIDTH - 1;
    localparam int DBIT = DATA_WIDTH - 2;

    tag_state_e             r_state;
    logic [ADDR_WIDTH-1:0]  r_sweep_cnt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_s1_vld;
    logic [TAG_WIDTH-1:0]   r_s1_tag;
    logic                   r_rsp_valid;
    logic                   r_rsp_hit;
    logic                   r_rsp_dirty;
    logic [TAG_WIDTH-1:0]   r_rsp_tag;

    tag_state_e             w_state_nxt;
    logic [ADDR_WIDTH-1:0]  w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic                   w_web;
    logic [DATA_WIDTH-1:0]  w_wdat;
    logic                   w_upd_rdy;
    logic                   w_lk_rdy;
    logic                   w_lk_fire;
    logic                   w_hit;
    logic                   w_dirty;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_sweep_cnt;
        w_addr      = r_addr;
        w_web       = 1'b1;
        w_wdat      = '0;
        w_upd_rdy   = 1'b0;
        w_lk_rdy    = 1'b0;
        w_lk_fire   = 1'b0;
        case (r_state)
            SWEEP: begin
                w_addr    = r_sweep_cnt;
                w_web     = 1'b0;
                w_cnt_nxt = r_sweep_cnt + 1'b1;
                if (r_sweep_cnt == '1) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // inv_all burns this cycle as idle; sweep writes start next cycle
                if (bus.inv_all) begin
                    w_state_nxt = SWEEP;
                    w_cnt_nxt   = '0;
                end else begin
                    w_upd_rdy = 1'b1;
                    w_lk_rdy  = ~bus.upd_valid;
                    if (bus.upd_valid) begin
                        w_addr                  = bus.upd_index;
                        w_web                   = 1'b0;
                        w_wdat[VBIT]            = bus.upd_v;
                        w_wdat[DBIT]            = bus.upd_d;
                        w_wdat[TAG_WIDTH-1:0]   = bus.upd_tag;
                    end else if (bus.lk_valid) begin
                        w_addr    = bus.lk_index;
                        w_lk_fire = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = SWEEP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_hit   = bus.sram_rdat[VBIT] & (bus.sram_rdat[TAG_WIDTH-1:0] == r_s1_tag);
    assign w_dirty = bus.sram_rdat[VBIT] & bus.sram_rdat[DBIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SWEEP;
            r_sweep_cnt <= '0;
            r_addr      <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_tag    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_dirty <= 1'b0;
            r_rsp_tag   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_cnt <= w_cnt_nxt;
            r_addr      <= w_addr;
            r_s1_vld    <= w_lk_fire;
            if (w_lk_fire) begin
                r_s1_tag <= bus.lk_tag;
            end
            r_rsp_valid <= r_s1_vld;
            if (r_s1_vld) begin
                r_rsp_hit   <= w_hit;
                r_rsp_dirty <= w_dirty;
                r_rsp_tag   <= bus.sram_rdat[TAG_WIDTH-1:0];
            end
        end
    end

    assign bus.lk_ready  = w_lk_rdy;
    assign bus.upd_ready = w_upd_rdy;
    assign bus.init_done = (r_state == RUN);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_hit   = r_rsp_hit;
    assign bus.rsp_dirty = r_rsp_dirty;
    assign bus.rsp_tag   = r_rsp_tag;
    assign bus.sram_addr = w_addr;
    assign bus.sram_web  = w_web;
    assign bus.sram_wdat = w_wdat;

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Bench for cache_tag_ctrl with a behavioural tag-SRAM and an array/queue reference model.
module tb_cache_tag_ctrl;
    import cache_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TW = 22;
    localparam int N  = 1 << AW;

    typedef struct {
        int          due;
        bit          hit;
        bit          dirty;
        bit [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_tag_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    cache_tag_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (!bus.sram_web) mem[bus.sram_addr] <= bus.sram_wdat;
        bus.sram_rdat <= mem[bus.sram_addr];
    end

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    bit          known    = 1'b0;
    int          sweep_left = N;
    bit          mv [N];
    bit          md [N];
    bit [TW-1:0] mt [N];
    logic [AW-1:0] last_addr = '0;
    exp_t        q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mk_entry(input logic v, input logic d, input logic [TW-1:0] t);
        tag_entry_t e;
        e.valid = v;
        e.dirty = d;
        e.pad   = '0;
        e.tag   = t;
        return e;
    endfunction

    // One clock: check outputs at negedge against the model, then advance the model at posedge.
    task automatic cycle();
        bit            upd_acc;
        bit            lk_acc;
        bit            run;
        int            idx;
        logic [AW-1:0] exp_addr;
        exp_t          e;
        upd_acc  = 1'b0;
        lk_acc   = 1'b0;
        run      = (sweep_left == 0);
        exp_addr = last_addr;
        @(negedge clk);
        if (known) begin
            upd_acc = run && !bus.inv_all && bus.upd_valid;
            lk_acc  = run && !bus.inv_all && !bus.upd_valid && bus.lk_valid;
            chk("upd_ready", 32'(bus.upd_ready), 32'(run && !bus.inv_all));
            chk("lk_ready", 32'(bus.lk_ready), 32'(run && !bus.inv_all && !bus.upd_valid));
            chk("init_done", 32'(bus.init_done), 32'(run));
            if (!run) begin
                exp_addr = AW'(N - sweep_left);
                chk("sweep_web", 32'(bus.sram_web), 32'(0));
                chk("sweep_wdat", bus.sram_wdat, 32'(0));
            end else if (upd_acc) begin
                exp_addr = bus.upd_index;
                chk("upd_web", 32'(bus.sram_web), 32'(0));
                chk("upd_wdat", bus.sram_wdat, mk_entry(bus.upd_v, bus.upd_d, bus.upd_tag));
            end else begin
                if (lk_acc) exp_addr = bus.lk_index;
                chk("read_web", 32'(bus.sram_web), 32'(1));
            end
            chk("sram_addr", 32'(bus.sram_addr), 32'(exp_addr));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'(1));
                chk("rsp_hit", 32'(bus.rsp_hit), 32'(e.hit));
                chk("rsp_dirty", 32'(bus.rsp_dirty), 32'(e.dirty));
                chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
            end else begin
                chk("rsp_idle", 32'(bus.rsp_valid), 32'(0));
            end
        end
        @(posedge clk);
        if (rst) begin
            known      = 1'b1;
            sweep_left = N;
            last_addr  = '0;
            q.delete();
        end else if (known) begin
            last_addr = exp_addr;
            if (!run) begin
                idx     = N - sweep_left;
                mv[idx] = 1'b0;
                md[idx] = 1'b0;
                mt[idx] = '0;
                sweep_left--;
            end else if (bus.inv_all) begin
                sweep_left = N;
            end else if (upd_acc) begin
                mv[bus.upd_index] = bus.upd_v;
                md[bus.upd_index] = bus.upd_d;
                mt[bus.upd_index] = bus.upd_tag;
            end else if (lk_acc) begin
                e.due   = cyc + 2;
                e.hit   = mv[bus.lk_index] && (mt[bus.lk_index] == bus.lk_tag);
                e.dirty = mv[bus.lk_index] && md[bus.lk_index];
                e.tag   = mt[bus.lk_index];
                q.push_back(e);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        bus.lk_valid  = 1'b0;
        bus.lk_index  = '0;
        bus.lk_tag    = '0;
        bus.upd_valid = 1'b0;
        bus.upd_index = '0;
        bus.upd_tag   = '0;
        bus.upd_v     = 1'b0;
        bus.upd_d     = 1'b0;
        bus.inv_all   = 1'b0;
    endtask

    task automatic idle(input int n);
        idle_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_upd(input logic [AW-1:0] idx, input logic [TW-1:0] t, input logic v, input logic d);
        idle_inputs();
        bus.upd_valid = 1'b1;
        bus.upd_index = idx;
        bus.upd_tag   = t;
        bus.upd_v     = v;
        bus.upd_d     = d;
        cycle();
    endtask

    task automatic do_lk(input logic [AW-1:0] idx, input logic [TW-1:0] t);
        idle_inputs();
        bus.lk_valid = 1'b1;
        bus.lk_index = idx;
        bus.lk_tag   = t;
        cycle();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_rsp_hit", 32'(bus.rsp_hit), 32'(0));
        chk("reset_rsp_dirty", 32'(bus.rsp_dirty), 32'(0));
        chk("reset_rsp_tag", 32'(bus.rsp_tag), 32'(0));
        rst = 1'b0;

        // Power-up sweep, then misses on a cleared array
        idle(N + 2);
        do_lk(8'h12, 22'h2A5A5);
        do_lk(8'hFF, 22'h0);

        // Fill and hit/miss on the same set
        do_upd(8'h12, 22'h2A5A5, 1'b1, 1'b0);
        do_lk(8'h12, 22'h2A5A5);
        do_lk(8'h12, 22'h00001);
        idle(3);

        // Back-to-back lookups on sets 0..7
        for (int i = 0; i < 8; i++) do_upd(AW'(i), TW'(i * 3 + 1), 1'(i % 2), 1'(i / 4));
        for (int i = 0; i < 8; i++) do_lk(AW'(i), TW'(i * 3 + 1));
        idle(3);

        // Update and lookup together: lookup waits one cycle and sees the write
        idle_inputs();
        bus.upd_valid = 1'b1; bus.upd_index = 8'h40; bus.upd_tag = 22'h155; bus.upd_v = 1'b1; bus.upd_d = 1'b1;
        bus.lk_valid  = 1'b1; bus.lk_index  = 8'h40; bus.lk_tag  = 22'h155;
        cycle();
        bus.upd_valid = 1'b0;
        cycle();
        idle(3);

        // inv_all with two lookups in flight to a valid entry
        do_upd(8'h05, 22'h3ABCD, 1'b1, 1'b1);
        do_lk(8'h05, 22'h3ABCD);
        do_lk(8'h05, 22'h3ABCD);
        idle_inputs();
        bus.inv_all = 1'b1;
        cycle();
        idle(N + 2);
        do_lk(8'h05, 22'h3ABCD);
        idle(3);

        // Randomised traffic on a few sets with a small tag alphabet
        for (int i = 0; i < 1500; i++) begin
            bus.upd_valid = ($urandom_range(0, 3) == 0);
            bus.upd_index = AW'($urandom_range(0, 15));
            bus.upd_tag   = TW'($urandom_range(0, 3));
            bus.upd_v     = 1'($urandom_range(0, 1));
            bus.upd_d     = 1'($urandom_range(0, 1));
            bus.lk_valid  = 1'($urandom_range(0, 1));
            bus.lk_index  = AW'($urandom_range(0, 15));
            bus.lk_tag    = TW'($urandom_range(0, 3));
            bus.inv_all   = ($urandom_range(0, 499) == 0);
            cycle();
        end
        idle(N + 4);

        // Reset while the sweep is writing index 100
        do_upd(8'h64, 22'h777, 1'b1, 1'b0);
        idle_inputs();
        bus.inv_all = 1'b1;
        cycle();
        idle(100);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(N + 2);
        do_lk(8'h64, 22'h777);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/cache_tag_ctrl.md
# cache_tag_ctrl

Port-0 initiator for `cache_tag_sram`: owns all reads and writes of the direct-mapped tag array on behalf of the cache controller. Provides a pipelined lookup channel (hit/miss, dirty, victim tag) and an update channel (fill, dirty-mark, invalidate), and clears the array after reset or on request. Sits between the cache FSM and `cache_tag_sram` port 0; port 1 is unused by this block.

## Interface
- `ADDR_WIDTH`, default 8: set-index width; the array holds 2^ADDR_WIDTH entries.
- `DATA_WIDTH`, default 32: tag SRAM word width.
- `TAG_WIDTH`, default 22: stored tag width; must be ≤ DATA_WIDTH-2.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `lk_valid` in 1: lookup request.
- `lk_ready` out 1: lookup accepted when `lk_valid & lk_ready`.
- `lk_index` in ADDR_WIDTH: set to look up.
- `lk_tag` in TAG_WIDTH: tag to compare.
- `rsp_valid` out 1: one-cycle pulse; lookup result valid. There is no backpressure.
- `rsp_hit` out 1: entry valid and tag equal.
- `rsp_dirty` out 1: stored dirty bit; qualified by the stored valid bit.
- `rsp_tag` out TAG_WIDTH: stored tag, used as the victim tag.
- `upd_valid` in 1: update request.
- `upd_ready` out 1: update accepted when `upd_valid & upd_ready`.
- `upd_index` in ADDR_WIDTH: set to write.
- `upd_tag` in TAG_WIDTH: tag to write.
- `upd_v` in 1: valid bit to write.
- `upd_d` in 1: dirty bit to write.
- `inv_all` in 1: single-cycle pulse that requests a full-array invalidate.
- `init_done` out 1: high while the block is in RUN.
- `sram_addr` out ADDR_WIDTH: connects to `p0_addr`.
- `sram_web` out 1: active-low write enable; connects to `p0_web` with NUM_WAYS=1.
- `sram_wdat` out DATA_WIDTH: connects to `p0_wdat`.
- `sram_rdat` in DATA_WIDTH: connects to `p0_rdat`; valid one cycle after the read address is presented.

## Operation
- Entry format: bit DATA_WIDTH-1 holds valid, bit DATA_WIDTH-2 holds dirty, bits TAG_WIDTH-1:0 hold the tag, all other bits are 0.
- FSM states:
  - SWEEP: `sweep_cnt` (ADDR_WIDTH bits) drives `sram_addr`, `sram_web=0`, `sram_wdat=0`. The counter increments every cycle. When the counter is at its all-ones value, that write is issued and the FSM moves to RUN.
  - RUN: normal service.
- Transitions:
  - `rst` → SWEEP with the counter at 0.
  - RUN with `inv_all=1` → SWEEP with the counter at 0. `inv_all` is ignored while in SWEEP.
- Arbitration in RUN, one SRAM access per cycle, priority inv_all > update > lookup.
  - `upd_ready = RUN & ~inv_all`.
  - `lk_ready = RUN & ~inv_all & ~upd_valid`.
  - `lk_ready` and `upd_ready` are low throughout SWEEP.
- Update accepted: write `{upd_v, upd_d, zero-pad, upd_tag}` to `upd_index`.
- Lookup accepted: `sram_web=1`, `sram_addr=lk_index`. The request tag is registered into stage S1.
- Stage S1, next cycle: compare against `sram_rdat`. `hit = rdat.valid & (rdat.tag == s1_tag)`. `rsp_dirty = rdat.valid & rdat.dirty`. Results are registered into S2 to drive the `rsp_*` outputs.
- Idle cycles in RUN: `sram_web=1`, and `sram_addr` holds its last value.
- Ordering: a lookup accepted in cycle N observes every update accepted before cycle N and none accepted after.
- `inv_all` while lookups are in flight: the in-flight lookups complete and return pre-sweep data. SWEEP writes begin the cycle after `inv_all`.

## Timing
- Lookup latency is 2. A lookup accepted at edge N gives `rsp_valid=1` in cycle N+2. Throughput is 1 lookup per cycle.
- Update latency: the SRAM write occurs in the accept cycle.
- A sweep lasts 2^ADDR_WIDTH cycles. `init_done` rises in the cycle after the last sweep write.
- Reset values:
  - `rsp_valid`, `rsp_hit`, `rsp_dirty`, `rsp_tag` = 0.
  - `lk_ready`, `upd_ready`, `init_done` = 0.
  - `sram_addr` = 0, `sram_web` = 0 (sweep write of entry 0), `sram_wdat` = 0.
- `rst` mid-sweep restarts the sweep at index 0.
- `rst` with lookups in flight discards them; `rsp_valid` is 0 from the cycle after `rst`.
- Counter wrap: the all-ones index is written exactly once per sweep, and there is no extra write of index 0.

## Structure
- `cache_pkg` contains:
  - `tag_entry_t`, a packed struct with fields valid, dirty, pad, tag.
  - `VALID_BIT` and `DIRTY_BIT` constants.
  - `tag_state_e`, an enum of SWEEP and RUN.
- There is no sub-module. The parent instantiates `cache_tag_ctrl` next to `cache_tag_sram` and ties port 1 off.

## Test plan
- Reset, then idle: writes occur to indices 0..255 with data 0. `init_done` rises at cycle 256. All later lookups return `rsp_hit=0`.
- Update index 0x12 with tag 0x2A5A5, v=1, d=0, then look up 0x12/0x2A5A5. Expect `rsp_hit=1` and `rsp_dirty=0` two cycles after acceptance. A lookup of 0x12/0x00001 gives `rsp_hit=0` with `rsp_tag=0x2A5A5`.
- Back-to-back lookups on indices 0..7 in consecutive cycles: eight consecutive `rsp_valid` pulses return in order.
- Assert `upd_valid` and `lk_valid` in the same cycle: `lk_ready=0` and the update writes. The lookup is accepted the next cycle and sees the updated entry.
- `inv_all` issued with two lookups in flight to a valid entry: both lookups return `rsp_hit=1`. There are then 256 cycles of `lk_ready=0`, after which the same lookup returns `rsp_hit=0`.
- `rst` asserted at sweep index 100: the sweep restarts at 0, and `init_done` rises 256 cycles after `rst` is released.
